hdmi_period_scheduler: RTL and testbench

- Per-pixel sequencer that chooses the period type for the TMDS encoders feeding the 10:1 serializer: control, video preamble/guard/data, or data-island preamble/guard/data.
- Schedules data islands into horizontal blanking, hands packet words out to the packet source through a valid/ack handshake, and owns the serializer reset release.
- Sits between the video timing counters and the TMDS channel encoders, in the clk_pixel domain.

---
 rtl/hdmi_period_scheduler.sv | 174 +++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel period sequencer for the TMDS encoders: control, video and data-island
// periods, island packet handshake, and serializer reset release.
module hdmi_period_scheduler #(
  parameter int DVI_OUTPUT       = 0,
  parameter int FRAME_WIDTH      = 800,
  parameter int FRAME_HEIGHT     = 525,
  parameter int SCREEN_START_X   = 160,
  parameter int SCREEN_START_Y   = 45,
  parameter int MAX_PACKETS      = 18,
  parameter int SER_RESET_CYCLES = 4
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic        packet_valid,
  output logic        packet_ack,
  output logic [4:0]  packet_word,
  output logic [2:0]  mode,
  output logic        ser_reset
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    LGUARD = 3'd2,
    DATA   = 3'd3,
    TGUARD = 3'd4
  } island_state_t;

  localparam logic [12:0] FW_W      = 13'(FRAME_WIDTH);
  localparam logic [11:0] FH_W      = 12'(FRAME_HEIGHT);
  localparam logic [12:0] START_X_W = 13'(SCREEN_START_X);
  localparam logic [11:0] START_Y_W = 12'(SCREEN_START_Y);
  localparam logic [12:0] GUARD_X_W = 13'(SCREEN_START_X - 2);
  localparam logic [12:0] PRE_X_W   = 13'(SCREEN_START_X - 10);
  localparam logic [4:0]  MAX_P_W   = 5'(MAX_PACKETS);
  localparam logic        ISLAND_EN = (DVI_OUTPUT == 0);
  localparam int          SRW       = $clog2(SER_RESET_CYCLES + 1);
  localparam logic [SRW-1:0] SR_MAX = SRW'(SER_RESET_CYCLES);

  island_state_t  st_r, st_s;
  logic [4:0]     cnt_r, cnt_s;
  logic [4:0]     pkts_r, pkts_s;
  logic           cont_r, cont_s;
  logic [2:0]     gap_r, gap_s;
  logic [2:0]     mode_s;
  logic [SRW-1:0] ser_cnt_r;
  logic [12:0]    cx_w;
  logic [11:0]    cy_w;
  logic           in_range_s;
  logic           start_ok_s;

  assign cx_w = {1'b0, cx};
  assign cy_w = {1'b0, cy};

  // Serializer reset: held through reset, released SER_RESET_CYCLES cycles later.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      ser_cnt_r <= '0;
      ser_reset <= 1'b1;
    end else begin
      if (ser_cnt_r != SR_MAX) begin
        ser_cnt_r <= ser_cnt_r + SRW'(1);
      end
      ser_reset <= (ser_cnt_r < SR_MAX);
    end
  end

  // Island state of the current pixel plus the mode it maps to.
  always_comb begin
    st_s       = st_r;
    cnt_s      = cnt_r;
    pkts_s     = pkts_r;
    cont_s     = 1'b0;
    gap_s      = gap_r;
    mode_s     = 3'd0;
    in_range_s = (cx_w < FW_W) && (cy_w < FH_W);
    // gap_r counts control pixels since the last trailing guard, saturating at 4
    start_ok_s = packet_valid && ISLAND_EN && (cx_w >= 13'd2) &&
                 (cx_w + 13'd56 <= PRE_X_W) && (gap_r == 3'd4);
    case (st_r)
      IDLE: begin
        cnt_s = 5'd0;
        if (start_ok_s) st_s = PRE;
        else            st_s = IDLE;
      end
      PRE: begin
        if (cnt_r == 5'd7) begin st_s = LGUARD; cnt_s = 5'd0; end
        else               cnt_s = cnt_r + 5'd1;
      end
      LGUARD: begin
        if (cnt_r == 5'd1) begin st_s = DATA; cnt_s = 5'd0; pkts_s = 5'd1; end
        else               cnt_s = cnt_r + 5'd1;
      end
      DATA: begin
        if (cnt_r == 5'd31) begin
          cnt_s = 5'd0;
          if (cont_r) begin st_s = DATA;   pkts_s = pkts_r + 5'd1; end
          else        begin st_s = TGUARD; end
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      TGUARD: begin
        if (cnt_r == 5'd1) begin st_s = IDLE; cnt_s = 5'd0; end
        else               cnt_s = cnt_r + 5'd1;
      end
      default: begin
        st_s  = IDLE;
        cnt_s = 5'd0;
      end
    endcase
    if (!in_range_s) begin
      st_s  = IDLE;
      cnt_s = 5'd0;
    end else begin
      cnt_s = cnt_s;
    end
    if (st_s == IDLE) begin
      if (st_r != IDLE)        gap_s = 3'd1;
      else if (gap_r < 3'd4)   gap_s = gap_r + 3'd1;
      else                     gap_s = 3'd4;
    end else begin
      gap_s = gap_r;
    end
    // Continuation is decided on word 31 and applied on the following pixel
    if (st_s == DATA && cnt_s == 5'd31) begin
      cont_s = packet_valid && (pkts_s < MAX_P_W) && (cx_w + 13'd47 <= PRE_X_W);
    end else begin
      cont_s = 1'b0;
    end
    case (st_s)
      PRE:     mode_s = 3'd4;
      LGUARD:  mode_s = 3'd5;
      DATA:    mode_s = 3'd6;
      TGUARD:  mode_s = 3'd5;
      default: begin
        if (in_range_s && cy_w >= START_Y_W) begin
          if (cx_w >= START_X_W)                   mode_s = 3'd3;
          else if (ISLAND_EN && cx_w >= GUARD_X_W) mode_s = 3'd2;
          else if (ISLAND_EN && cx_w >= PRE_X_W)   mode_s = 3'd1;
          else                                     mode_s = 3'd0;
        end else begin
          mode_s = 3'd0;
        end
      end
    endcase
  end

  // Island state register and registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      st_r        <= IDLE;
      cnt_r       <= 5'd0;
      pkts_r      <= 5'd0;
      cont_r      <= 1'b0;
      gap_r       <= 3'd4;
      mode        <= 3'd0;
      packet_ack  <= 1'b0;
      packet_word <= 5'd0;
    end else begin
      st_r        <= st_s;
      cnt_r       <= cnt_s;
      pkts_r      <= pkts_s;
      cont_r      <= cont_s;
      gap_r       <= gap_s;
      mode        <= mode_s;
      packet_ack  <= (st_s == DATA) && (cnt_s == 5'd0);
      packet_word <= (st_s == DATA) ? cnt_s : 5'd0;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: default, single-packet and DVI instances
// share one stimulus stream; expected values are hand-derived pixel ranges.
module tb_hdmi_period_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [11:0] cx;
  logic [10:0] cy;
  logic        packet_valid;
  logic        ack_a, ack_b, ack_c;
  logic [4:0]  word_a, word_b, word_c;
  logic [2:0]  mode_a, mode_b, mode_c;
  logic        ser_a, ser_b, ser_c;
  int          errors = 0;
  int          checks = 0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_period_scheduler u_dut (
    .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .packet_valid(packet_valid),
    .packet_ack(ack_a), .packet_word(word_a), .mode(mode_a), .ser_reset(ser_a));

  hdmi_period_scheduler #(.MAX_PACKETS(1)) u_max1 (
    .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .packet_valid(packet_valid),
    .packet_ack(ack_b), .packet_word(word_b), .mode(mode_b), .ser_reset(ser_b));

  hdmi_period_scheduler #(.DVI_OUTPUT(1)) u_dvi (
    .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .packet_valid(packet_valid),
    .packet_ack(ack_c), .packet_word(word_c), .mode(mode_c), .ser_reset(ser_c));

  // Expected mode at offset 'off' from island start with 'len' data cycles.
  function automatic logic [2:0] isl_mode(input int off, input int len);
    if (off < 0)             return 3'd0;
    else if (off < 8)        return 3'd4;
    else if (off < 10)       return 3'd5;
    else if (off < 10 + len) return 3'd6;
    else if (off < 12 + len) return 3'd5;
    else                     return 3'd0;
  endfunction

  function automatic logic [4:0] isl_word(input int off, input int len);
    if (off >= 10 && off < 10 + len) return 5'((off - 10) % 32);
    else                             return 5'd0;
  endfunction

  function automatic logic isl_ack(input int off, input int len);
    return (off >= 10 && off < 10 + len && ((off - 10) % 32) == 0);
  endfunction

  task automatic step(input int x, input int y, input logic v);
    cx = 12'(x);
    cy = 11'(y);
    packet_valid = v;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1'b0);
      checks++;
      if (mode_a !== 3'd0 || ser_a !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d mode=%0d ser=%0b want mode=0 ser=1", i, mode_a, ser_a);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1'b0);
      checks++;
      if (ser_a !== (k <= 4) || mode_a !== 3'd0) begin
        errors++;
        $display("FAIL ser_release k=%0d ser=%0b want %0b mode=%0d", k, ser_a, (k <= 4), mode_a);
      end
    end
  endtask

  task automatic test_video_line();
    logic [2:0] exp_m;
    logic [2:0] exp_d;
    for (int x = 0; x < 800; x++) begin
      step(x, 100, 1'b0);
      exp_m = (x >= 160) ? 3'd3 : (x >= 158) ? 3'd2 : (x >= 150) ? 3'd1 : 3'd0;
      exp_d = (x >= 160) ? 3'd3 : 3'd0;
      checks += 3;
      if (mode_a !== exp_m) begin
        errors++; $display("FAIL video_mode cx=%0d got %0d want %0d", x, mode_a, exp_m);
      end
      if (mode_c !== exp_d) begin
        errors++; $display("FAIL dvi_video cx=%0d got %0d want %0d", x, mode_c, exp_d);
      end
      if (ack_a !== 1'b0 || word_a !== 5'd0) begin
        errors++; $display("FAIL video_ack cx=%0d ack=%0b word=%0d want 0", x, ack_a, word_a);
      end
    end
  endtask

  task automatic test_island_line(input int y);
    int offb;
    for (int x = 0; x < 800; x++) begin
      step(x, y, 1'b1);
      offb = (x <= 49) ? x - 2 : x - 50;
      checks += 5;
      if (mode_a !== isl_mode(x - 2, 96) || word_a !== isl_word(x - 2, 96)) begin
        errors++;
        $display("FAIL island_mode y=%0d cx=%0d mode=%0d word=%0d want %0d %0d",
                 y, x, mode_a, word_a, isl_mode(x - 2, 96), isl_word(x - 2, 96));
      end
      if (ack_a !== isl_ack(x - 2, 96)) begin
        errors++; $display("FAIL island_ack y=%0d cx=%0d got %0b want %0b", y, x, ack_a, isl_ack(x - 2, 96));
      end
      if (mode_b !== isl_mode(offb, 32) || word_b !== isl_word(offb, 32)) begin
        errors++;
        $display("FAIL max1_mode y=%0d cx=%0d mode=%0d word=%0d want %0d %0d",
                 y, x, mode_b, word_b, isl_mode(offb, 32), isl_word(offb, 32));
      end
      if (ack_b !== isl_ack(offb, 32)) begin
        errors++; $display("FAIL max1_ack y=%0d cx=%0d got %0b want %0b", y, x, ack_b, isl_ack(offb, 32));
      end
      if (mode_c !== 3'd0 || ack_c !== 1'b0) begin
        errors++; $display("FAIL dvi_island cx=%0d mode=%0d ack=%0b want 0 0", x, mode_c, ack_c);
      end
    end
  endtask

  task automatic test_late_valid(input int rise, input int base);
    logic [2:0] exp_m;
    logic       exp_k;
    for (int x = 0; x < 800; x++) begin
      step(x, 10, (x >= rise));
      exp_m = (base < 0) ? 3'd0 : isl_mode(x - base, 32);
      exp_k = (base < 0) ? 1'b0 : isl_ack(x - base, 32);
      checks += 2;
      if (mode_a !== exp_m || ack_a !== exp_k) begin
        errors++;
        $display("FAIL late_valid rise=%0d cx=%0d mode=%0d ack=%0b want %0d %0b", rise, x, mode_a, ack_a, exp_m, exp_k);
      end
      if (mode_b !== exp_m) begin
        errors++; $display("FAIL late_valid_max1 rise=%0d cx=%0d got %0d want %0d", rise, x, mode_b, exp_m);
      end
    end
  endtask

  task automatic test_reset_mid_island();
    for (int x = 0; x < 30; x++) step(x, 10, 1'b1);
    checks++;
    if (mode_a !== 3'd6 || word_a !== 5'd17) begin
      errors++; $display("FAIL mid_pre_reset mode=%0d word=%0d want 6 17", mode_a, word_a);
    end
    reset = 1'b1;
    step(30, 10, 1'b1);
    checks++;
    if (mode_a !== 3'd0 || ack_a !== 1'b0 || word_a !== 5'd0 || ser_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset mode=%0d ack=%0b word=%0d ser=%0b want 0 0 0 1", mode_a, ack_a, word_a, ser_a);
    end
    reset = 1'b0;
    for (int x = 31; x < 800; x++) begin
      step(x, 10, 1'b0);
      checks++;
      if (mode_a !== 3'd0 || ack_a !== 1'b0) begin
        errors++; $display("FAIL post_reset cx=%0d mode=%0d ack=%0b want 0 0", x, mode_a, ack_a);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 6; i++) begin
      step(800 + i, 100, 1'b1);
      checks++;
      if (mode_a !== 3'd0 || mode_c !== 3'd0) begin
        errors++; $display("FAIL oor_cx cx=%0d mode=%0d dvi=%0d want 0", 800 + i, mode_a, mode_c);
      end
    end
    step(200, 600, 1'b1);
    checks++;
    if (mode_a !== 3'd0 || ack_a !== 1'b0) begin
      errors++; $display("FAIL oor_cy mode=%0d ack=%0b want 0 0", mode_a, ack_a);
    end
  endtask

  initial begin
    reset = 1'b1;
    cx = 12'd0;
    cy = 11'd0;
    packet_valid = 1'b0;
    test_reset();
    test_video_line();
    test_island_line(10);
    test_late_valid(95, -1);
    test_late_valid(94, 94);
    test_out_of_range();
    test_reset_mid_island();
    test_island_line(11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
